// File: rtl/bus_slave_regs_if.sv
// Bus between the address decoder/master and the register slave.
// Handshake: a transaction starts at a rising edge that samples Cs_=0 and As_=0; the
// slave answers with Rdy_=0 for exactly one cycle, carrying RdData for reads.
interface bus_slave_regs_if;
  logic        Cs_;
  logic        As_;
  logic        RW;
  logic [29:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Rdy_;

  modport master (
    output Cs_, As_, RW, Addr, WrData,
    input  RdData, Rdy_
  );

  modport slave (
    input  Cs_, As_, RW, Addr, WrData,
    output RdData, Rdy_
  );
endinterface

// File: rtl/bus_slave_regs.sv
// Eight-word register slave: words 0..6 read/write, word 7 a free-running cycle counter.
// Each accepted strobe is answered by a single Rdy_ pulse after WAIT_CYCLES wait states.
module bus_slave_regs #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_,
  bus_slave_regs_if.slave  bus,
  output logic [31:0]      Ctrl,
  output logic [1:0]       o_state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READY = 2'd2} state_t;

  localparam logic [3:0] LP_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic        w_go_ready;
  logic [3:0]  r_wait_cnt;
  logic [2:0]  r_addr;
  logic        r_rw;
  logic [31:0] r_wdata;
  logic [31:0] r_regs [0:6];
  logic [31:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_rdy_n;
  logic [2:0]  w_addr;
  logic        w_rw;
  logic [31:0] w_wdata;
  logic [31:0] w_rd_val;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_go_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.As_ && !bus.Cs_) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next_state = READY;
            w_go_ready   = 1'b1;
          end else begin
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_next_state = READY;
          w_go_ready   = 1'b1;
        end
      end
      READY:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A zero-wait access completes on its own strobe edge, before the fields are latched.
  always_comb begin
    w_addr  = r_addr;
    w_rw    = r_rw;
    w_wdata = r_wdata;
    if (r_state == IDLE) begin
      w_addr  = bus.Addr[2:0];
      w_rw    = bus.RW;
      w_wdata = bus.WrData;
    end
    w_rd_val = r_cnt;
    for (int i = 0; i < 7; i++) begin
      if (w_addr == 3'(i)) w_rd_val = r_regs[i];
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
      r_addr     <= 3'd0;
      r_rw       <= 1'b0;
      r_wdata    <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr     <= bus.Addr[2:0];
        r_rw       <= bus.RW;
        r_wdata    <= bus.WrData;
        r_wait_cnt <= LP_WAIT_LOAD;
      end else if (r_state == WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_cnt <= 32'd0;
    else         r_cnt <= r_cnt + 32'd1;
  end

  // Rdy_ and RdData are registered so the bus sees clean one-cycle pulses that OR together.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < 7; i++) r_regs[i] <= 32'd0;
      r_rdy_n <= 1'b1;
      r_rdata <= 32'd0;
    end else begin
      r_rdy_n <= !w_go_ready;
      r_rdata <= (w_go_ready && w_rw) ? w_rd_val : 32'd0;
      if (w_go_ready && !w_rw) begin
        for (int i = 0; i < 7; i++) begin
          if (w_addr == 3'(i)) r_regs[i] <= w_wdata;
        end
      end
    end
  end

  assign bus.Rdy_    = r_rdy_n;
  assign bus.RdData  = r_rdata;
  assign Ctrl        = r_regs[0];
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_bus_slave_regs.sv
// Bench for bus_slave_regs: three instances (0, 1 and 3 wait cycles) checked against
// an array model of the register file and a cycle count since reset release.
module tb_bus_slave_regs;
  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned rst_edges = 0;
  int wc_of [3] = '{0, 1, 3};
  logic [31:0] mdl [3][8];
  logic [31:0] ctrl0, ctrl1, ctrl3;
  logic [1:0]  st0, st1, st3;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) rst_edges <= 0;
    else         rst_edges <= rst_edges + 1;
  end

  bus_slave_regs_if bif0();
  bus_slave_regs_if bif1();
  bus_slave_regs_if bif3();

  bus_slave_regs #(.WAIT_CYCLES(0)) u_d0 (.clk(clk), .reset_(reset_), .bus(bif0.slave), .Ctrl(ctrl0), .o_state_dbg(st0));
  bus_slave_regs #(.WAIT_CYCLES(1)) u_d1 (.clk(clk), .reset_(reset_), .bus(bif1.slave), .Ctrl(ctrl1), .o_state_dbg(st1));
  bus_slave_regs #(.WAIT_CYCLES(3)) u_d3 (.clk(clk), .reset_(reset_), .bus(bif3.slave), .Ctrl(ctrl3), .o_state_dbg(st3));

  task automatic set_bus(input int k, input logic cs, input logic strobe_n, input logic rw,
                         input logic [29:0] a, input logic [31:0] wd);
    case (k)
      0: begin bif0.Cs_ = cs; bif0.As_ = strobe_n; bif0.RW = rw; bif0.Addr = a; bif0.WrData = wd; end
      1: begin bif1.Cs_ = cs; bif1.As_ = strobe_n; bif1.RW = rw; bif1.Addr = a; bif1.WrData = wd; end
      default: begin bif3.Cs_ = cs; bif3.As_ = strobe_n; bif3.RW = rw; bif3.Addr = a; bif3.WrData = wd; end
    endcase
  endtask

  function automatic logic get_rdy(input int k);
    case (k)
      0: return bif0.Rdy_;
      1: return bif1.Rdy_;
      default: return bif3.Rdy_;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int k);
    case (k)
      0: return bif0.RdData;
      1: return bif1.RdData;
      default: return bif3.RdData;
    endcase
  endfunction

  function automatic logic [31:0] get_ctrl(input int k);
    case (k)
      0: return ctrl0;
      1: return ctrl1;
      default: return ctrl3;
    endcase
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) mdl[k][i] = 32'd0;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) set_bus(k, 1'b1, 1'b1, 1'b0, 30'd0, 32'd0);
  endtask

  // Called and returns at posedge+1. Checks Rdy_, RdData and Ctrl every cycle of the access.
  task automatic do_access(input int k, input logic rw, input logic [29:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int unsigned rk);
    int wc;
    logic [2:0] idx;
    logic [31:0] old_ctrl, exp_rd, exp;
    wc = wc_of[k];
    idx = a[2:0];
    old_ctrl = mdl[k][0];
    exp_rd = rw ? mdl[k][idx] : 32'd0;
    rd = 32'd0;
    rk = 0;
    if (!rw && idx != 3'd7) mdl[k][idx] = wd;
    set_bus(k, 1'b0, 1'b0, rw, a, wd);
    @(posedge clk); #1;
    set_bus(k, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 30'($urandom), $urandom);
    for (int n = 1; n <= wc + 3; n++) begin
      @(negedge clk);
      checks++;
      if (get_rdy(k) !== ((n == wc + 1) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL rdy k=%0d a=%0d n=%0d got=%b exp=%b", k, idx, n, get_rdy(k), (n != wc + 1));
      end
      if (n == wc + 1) begin
        rd = get_rd(k);
        rk = rst_edges;
      end
      if (!(rw && idx == 3'd7 && n == wc + 1)) begin
        exp = (n == wc + 1) ? exp_rd : 32'd0;
        checks++;
        if (get_rd(k) !== exp) begin
          errors++;
          $display("FAIL rddata k=%0d a=%0d n=%0d got=%h exp=%h", k, idx, n, get_rd(k), exp);
        end
      end
      exp = (n >= wc + 1) ? mdl[k][0] : old_ctrl;
      checks++;
      if (get_ctrl(k) !== exp) begin
        errors++;
        $display("FAIL ctrl k=%0d n=%0d got=%h exp=%h", k, n, get_ctrl(k), exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_all();
    reset_ = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_rdy(k) !== 1'b1 || get_rd(k) !== 32'd0 || get_ctrl(k) !== 32'd0) begin
        errors++;
        $display("FAIL reset_state k=%0d rdy=%b rd=%h ctrl=%h exp rdy=1 rd=0 ctrl=0", k, get_rdy(k), get_rd(k), get_ctrl(k));
      end
    end
    // Strobe already present when reset releases: must be taken at the first edge.
    set_bus(1, 1'b0, 1'b0, 1'b1, 30'd2, 32'd0);
    #1 reset_ = 1'b1;
    @(posedge clk); #1;
    set_bus(1, 1'b1, 1'b1, 1'b0, 30'd0, 32'd0);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      checks++;
      if (get_rdy(1) !== ((n == 2) ? 1'b0 : 1'b1) || get_rd(1) !== 32'd0) begin
        errors++;
        $display("FAIL first_strobe n=%0d rdy=%b rd=%h exp rdy=%b rd=0", n, get_rdy(1), get_rd(1), (n != 2));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cs_high();
    logic [31:0] rd;
    int unsigned rk;
    set_bus(1, 1'b1, 1'b0, 1'b0, 30'd3, 32'h1234);
    @(posedge clk); #1;
    set_bus(1, 1'b1, 1'b1, 1'b0, 30'd0, 32'd0);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      checks++;
      if (get_rdy(1) !== 1'b1) begin
        errors++;
        $display("FAIL cs_high_rdy n=%0d got=%b exp=1", n, get_rdy(1));
      end
    end
    @(posedge clk); #1;
    do_access(1, 1'b1, 30'd3, 32'd0, rd, rk);
  endtask

  task automatic test_wait_latency();
    logic [31:0] rd;
    int unsigned rk;
    do_access(1, 1'b0, 30'd2, 32'hDEADBEEF, rd, rk);
    do_access(1, 1'b1, 30'd2, 32'd0, rd, rk);
    do_access(0, 1'b0, 30'd0, 32'h00000005, rd, rk);
    do_access(2, 1'b0, {27'h5A5A5A5, 3'd1}, 32'h0BADF00D, rd, rk);
    do_access(2, 1'b1, 30'd1, 32'd0, rd, rk);
  endtask

  task automatic test_counter();
    logic [31:0] r1, r2, rd;
    int unsigned k1, k2, rk;
    int gap;
    do_access(1, 1'b0, 30'd7, 32'hFFFFFFFF, rd, rk);
    do_access(1, 1'b1, 30'd7, 32'd0, r1, k1);
    gap = $urandom_range(3, 40);
    repeat (gap) @(posedge clk);
    #1;
    do_access(1, 1'b1, 30'd7, 32'd0, r2, k2);
    checks++;
    if (r1 !== 32'(k1 - 1) && r1 !== 32'(k1)) begin
      errors++;
      $display("FAIL counter_value got=%h exp=%h", r1, 32'(k1 - 1));
    end
    checks++;
    if ((r2 - r1) !== 32'(k2 - k1)) begin
      errors++;
      $display("FAIL counter_delta got=%0d exp=%0d", r2 - r1, k2 - k1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp;
    int unsigned rk;
    logic exp_rdy;
    do_access(1, 1'b0, 30'd1, $urandom, rd, rk);
    do_access(1, 1'b0, 30'd6, $urandom, rd, rk);
    do_access(1, 1'b0, 30'd5, $urandom, rd, rk);
    set_bus(1, 1'b0, 1'b0, 1'b1, 30'd1, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      case (c)
        1: set_bus(1, 1'b0, 1'b0, 1'b0, 30'd5, ~mdl[1][5]);
        3: set_bus(1, 1'b0, 1'b0, 1'b1, 30'd6, 32'd0);
        default: set_bus(1, 1'b1, 1'b1, 1'b0, 30'd0, 32'd0);
      endcase
      @(negedge clk);
      exp_rdy = !(c == 2 || c == 5);
      exp = (c == 2) ? mdl[1][1] : (c == 5) ? mdl[1][6] : 32'd0;
      checks++;
      if (get_rdy(1) !== exp_rdy || get_rd(1) !== exp) begin
        errors++;
        $display("FAIL b2b c=%0d rdy=%b rd=%h exp rdy=%b rd=%h", c, get_rdy(1), get_rd(1), exp_rdy, exp);
      end
    end
    @(posedge clk); #1;
    do_access(1, 1'b1, 30'd5, 32'd0, rd, rk);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int unsigned rk;
    for (int i = 0; i < 45; i++) begin
      do_access(i % 3, 1'($urandom_range(0, 1)), 30'($urandom), $urandom, rd, rk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int unsigned rk;
    set_bus(2, 1'b0, 1'b0, 1'b0, 30'd4, 32'hA5A5A5A5);
    @(posedge clk); #1;
    set_bus(2, 1'b1, 1'b1, 1'b0, 30'd0, 32'd0);
    @(negedge clk);
    reset_ = 1'b0;
    clear_model();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_rdy(k) !== 1'b1 || get_rd(k) !== 32'd0 || get_ctrl(k) !== 32'd0) begin
        errors++;
        $display("FAIL async_reset k=%0d rdy=%b rd=%h ctrl=%h exp rdy=1 rd=0 ctrl=0", k, get_rdy(k), get_rd(k), get_ctrl(k));
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if (get_rdy(2) !== 1'b1) begin
        errors++;
        $display("FAIL abort_rdy n=%0d got=%b exp=1", n, get_rdy(2));
      end
    end
    @(posedge clk); #1;
    do_access(2, 1'b1, 30'd4, 32'd0, rd, rk);
    do_access(0, 1'b1, 30'd0, 32'd0, rd, rk);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cs_high();
    test_wait_latency();
    test_counter();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
